// File: rtl/score_keeper.sv
// Match controller: counts points, freezes play after each point, pulses
// serve_rst before play resumes, and latches game-over with the winner.
module score_keeper #(
   parameter int SCORE_W     = 4,
   parameter int WIN_SCORE   = 9,
   parameter int HOLD_FRAMES = 60
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               goal_p1,
   input  logic               goal_p2,
   input  logic               new_game,
   output logic [SCORE_W-1:0] score_p1,
   output logic [SCORE_W-1:0] score_p2,
   output logic               serve_rst,
   output logic               freeze,
   output logic               game_over,
   output logic               winner
);

   localparam int CNT_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
   localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLD_FRAMES - 1);
   localparam logic [SCORE_W-1:0] WIN_M1    = SCORE_W'(WIN_SCORE - 1);

   typedef enum logic [1:0] {S_PLAY, S_HOLD, S_SERVE, S_OVER} state_t;

   state_t             r_state;
   logic [SCORE_W-1:0] r_score_p1;
   logic [SCORE_W-1:0] r_score_p2;
   logic               r_serve_rst;
   logic               r_freeze;
   logic               r_game_over;
   logic               r_winner;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_goal_p1_q;
   logic               r_goal_p2_q;
   logic               r_new_game_q;

   state_t             w_state_nx;
   logic [SCORE_W-1:0] w_score_p1_nx;
   logic [SCORE_W-1:0] w_score_p2_nx;
   logic               w_game_over_nx;
   logic               w_winner_nx;
   logic [CNT_W-1:0]   w_cnt_nx;
   logic               w_rise_p1;
   logic               w_rise_p2;
   logic               w_rise_ng;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_SERVE;
      else      r_state <= w_state_nx;
   end

   always_comb begin
      w_rise_p1      = goal_p1 & ~r_goal_p1_q;
      w_rise_p2      = goal_p2 & ~r_goal_p2_q;
      w_rise_ng      = new_game & ~r_new_game_q;
      w_state_nx     = r_state;
      w_score_p1_nx  = r_score_p1;
      w_score_p2_nx  = r_score_p2;
      w_game_over_nx = r_game_over;
      w_winner_nx    = r_winner;
      w_cnt_nx       = r_cnt;
      if (w_rise_ng) begin
         w_score_p1_nx  = '0;
         w_score_p2_nx  = '0;
         w_game_over_nx = 1'b0;
         w_winner_nx    = 1'b0;
         w_state_nx     = S_SERVE;
      end else begin
         case (r_state)
            S_PLAY: begin
               if (w_rise_p1 && w_rise_p2) begin
                  w_state_nx = S_HOLD;
                  w_cnt_nx   = HOLD_LOAD;
               end else if (w_rise_p1) begin
                  w_score_p1_nx = r_score_p1 + SCORE_W'(1);
                  if (r_score_p1 == WIN_M1) begin
                     w_state_nx     = S_OVER;
                     w_game_over_nx = 1'b1;
                     w_winner_nx    = 1'b0;
                  end else begin
                     w_state_nx = S_HOLD;
                     w_cnt_nx   = HOLD_LOAD;
                  end
               end else if (w_rise_p2) begin
                  w_score_p2_nx = r_score_p2 + SCORE_W'(1);
                  if (r_score_p2 == WIN_M1) begin
                     w_state_nx     = S_OVER;
                     w_game_over_nx = 1'b1;
                     w_winner_nx    = 1'b1;
                  end else begin
                     w_state_nx = S_HOLD;
                     w_cnt_nx   = HOLD_LOAD;
                  end
               end
            end
            S_HOLD: begin
               if (r_cnt == '0) w_state_nx = S_SERVE;
               else             w_cnt_nx   = r_cnt - CNT_W'(1);
            end
            // The cycle that shows the serve pulse is the last SERVE cycle;
            // straight out of reset SERVE therefore spans two cycles.
            S_SERVE: begin
               if (r_serve_rst) w_state_nx = S_PLAY;
            end
            S_OVER: begin
               w_state_nx = S_OVER;
            end
            default: begin
               w_state_nx = S_SERVE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_score_p1   <= '0;
         r_score_p2   <= '0;
         r_serve_rst  <= 1'b0;
         r_freeze     <= 1'b1;
         r_game_over  <= 1'b0;
         r_winner     <= 1'b0;
         r_cnt        <= '0;
         r_goal_p1_q  <= 1'b1;
         r_goal_p2_q  <= 1'b1;
         r_new_game_q <= 1'b1;
      end else begin
         r_score_p1   <= w_score_p1_nx;
         r_score_p2   <= w_score_p2_nx;
         r_serve_rst  <= (w_state_nx == S_SERVE);
         r_freeze     <= (w_state_nx != S_PLAY);
         r_game_over  <= w_game_over_nx;
         r_winner     <= w_winner_nx;
         r_cnt        <= w_cnt_nx;
         r_goal_p1_q  <= goal_p1;
         r_goal_p2_q  <= goal_p2;
         r_new_game_q <= new_game;
      end
   end

   assign score_p1  = r_score_p1;
   assign score_p2  = r_score_p2;
   assign serve_rst = r_serve_rst;
   assign freeze    = r_freeze;
   assign game_over = r_game_over;
   assign winner    = r_winner;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: a frame-count model checked every cycle,
// plus literal expectations for each scenario.
module tb_score_keeper;

   localparam int SW  = 4;
   localparam int WIN = 9;
   localparam int HF  = 60;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          goal_p1 = 1'b0;
   logic          goal_p2 = 1'b0;
   logic          new_game = 1'b0;
   logic [SW-1:0] score_p1;
   logic [SW-1:0] score_p2;
   logic          serve_rst;
   logic          freeze;
   logic          game_over;
   logic          winner;

   int checks = 0;
   int errors = 0;

   score_keeper #(.SCORE_W(SW), .WIN_SCORE(WIN), .HOLD_FRAMES(HF)) dut (
      .clk(clk), .rst(rst), .goal_p1(goal_p1), .goal_p2(goal_p2),
      .new_game(new_game), .score_p1(score_p1), .score_p2(score_p2),
      .serve_rst(serve_rst), .freeze(freeze), .game_over(game_over),
      .winner(winner)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: m_left = frozen frames still to come (including the current
   // one); the serve pulse shows on the last of them; 0 means live play.
   int m_s1 = 0, m_s2 = 0, m_left = 2;
   bit m_over = 0, m_win = 0;
   bit m_p1q = 1, m_p2q = 1, m_ngq = 1;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_s1 = 0; m_s2 = 0; m_left = 2; m_over = 0; m_win = 0;
         m_p1q = 1; m_p2q = 1; m_ngq = 1;
      end else begin
         bit r1, r2, rn;
         r1 = goal_p1 && !m_p1q;
         r2 = goal_p2 && !m_p2q;
         rn = new_game && !m_ngq;
         if (rn) begin
            m_s1 = 0; m_s2 = 0; m_over = 0; m_win = 0; m_left = 1;
         end else if (m_over) begin
            m_left = 0;
         end else if (m_left > 0) begin
            m_left--;
         end else if (r1 && r2) begin
            m_left = HF + 1;
         end else if (r1) begin
            m_s1++;
            if (m_s1 == WIN) begin m_over = 1; m_win = 0; end
            else m_left = HF + 1;
         end else if (r2) begin
            m_s2++;
            if (m_s2 == WIN) begin m_over = 1; m_win = 1; end
            else m_left = HF + 1;
         end
         m_p1q = goal_p1; m_p2q = goal_p2; m_ngq = new_game;
      end
   end

   always @(negedge clk) begin
      chk("score_p1", int'(score_p1), m_s1);
      chk("score_p2", int'(score_p2), m_s2);
      chk("serve_rst", int'(serve_rst), int'(m_left == 1 && !m_over));
      chk("freeze", int'(freeze), int'(m_left != 0 || m_over));
      chk("game_over", int'(game_over), int'(m_over));
      chk("winner", int'(winner), int'(m_win));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Play out one point: goals set by caller stay high for drop_after
   // edges; counts frozen cycles without/with serve until play resumes.
   task automatic point_cycle(input int drop_after, output int nhold, output int nserve);
      bit done = 0;
      nhold = 0;
      nserve = 0;
      for (int i = 1; i <= 200; i++) begin
         tick();
         if (i == drop_after) begin goal_p1 = 1'b0; goal_p2 = 1'b0; end
         if (!freeze) begin done = 1; break; end
         if (serve_rst) nserve++;
         else nhold++;
      end
      chk("point_timeout", int'(done), 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int nh, ns;
      #1 rst = 1'b0;
      repeat (2) tick();
      chk("rst_score_p1", int'(score_p1), 0);
      chk("rst_serve", int'(serve_rst), 0);
      chk("rst_freeze", int'(freeze), 1);
      chk("rst_game_over", int'(game_over), 0);
      rst = 1'b1;

      // 1: serve pulse on first cycle, play on the second
      tick();
      chk("t1_serve", int'(serve_rst), 1);
      chk("t1_freeze_c1", int'(freeze), 1);
      tick();
      chk("t1_freeze_c2", int'(freeze), 0);
      chk("t1_serve_c2", int'(serve_rst), 0);

      // 2: goal_p1 held for 5 cycles counts once
      goal_p1 = 1'b1;
      point_cycle(5, nh, ns);
      chk("t2_hold_cycles", nh, 60);
      chk("t2_serve_pulses", ns, 1);
      chk("t2_score_p1", int'(score_p1), 1);
      chk("t2_score_p2", int'(score_p2), 0);

      // 3: simultaneous goals: no score change, still a full hold
      goal_p1 = 1'b1;
      goal_p2 = 1'b1;
      point_cycle(1, nh, ns);
      chk("t3_hold_cycles", nh, 60);
      chk("t3_serve_pulses", ns, 1);
      chk("t3_score_p1", int'(score_p1), 1);
      chk("t3_score_p2", int'(score_p2), 0);

      // 4: player 2 reaches WIN_SCORE
      for (int k = 0; k < WIN - 1; k++) begin
         goal_p2 = 1'b1;
         point_cycle(1, nh, ns);
      end
      chk("t4_score_p2_pre", int'(score_p2), WIN - 1);
      goal_p2 = 1'b1;
      tick();
      goal_p2 = 1'b0;
      chk("t4_game_over", int'(game_over), 1);
      chk("t4_winner", int'(winner), 1);
      chk("t4_score_p2", int'(score_p2), 9);
      ns = 0;
      for (int k = 0; k < 8; k++) begin
         goal_p1 = (k % 2 == 0);
         goal_p2 = (k % 3 == 0);
         tick();
         if (serve_rst) ns++;
      end
      goal_p1 = 1'b0;
      goal_p2 = 1'b0;
      chk("t4_no_serve", ns, 0);
      chk("t4_score_p1_held", int'(score_p1), 1);
      chk("t4_score_p2_held", int'(score_p2), 9);

      // 5: new_game from OVER, held high without retrigger
      new_game = 1'b1;
      tick();
      chk("t5_score_p1", int'(score_p1), 0);
      chk("t5_score_p2", int'(score_p2), 0);
      chk("t5_game_over", int'(game_over), 0);
      chk("t5_serve", int'(serve_rst), 1);
      tick();
      chk("t5_play", int'(freeze), 0);
      ns = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (serve_rst || freeze) ns++;
      end
      chk("t5_no_retrigger", ns, 0);
      new_game = 1'b0;

      // 6: async reset mid-hold with goal_p1 held
      goal_p1 = 1'b1;
      repeat (10) tick();
      chk("t6_in_hold", int'(freeze), 1);
      chk("t6_pre_score", int'(score_p1), 1);
      #2 rst = 1'b0;
      #1;
      chk("t6_rst_score_p1", int'(score_p1), 0);
      chk("t6_rst_freeze", int'(freeze), 1);
      chk("t6_rst_serve", int'(serve_rst), 0);
      tick();
      rst = 1'b1;
      repeat (6) tick();
      chk("t6_play", int'(freeze), 0);
      chk("t6_no_credit", int'(score_p1), 0);
      goal_p1 = 1'b0;
      tick();
      goal_p1 = 1'b1;
      tick();
      chk("t6_credit", int'(score_p1), 1);
      goal_p1 = 1'b0;
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
